// File: rtl/line_window_3x3.sv
// Two-line buffered 3x3 neighbourhood generator for a raster pixel stream.
// One window per interior pixel, presented one clock after its bottom-right pixel.
module line_window_3x3 #(
  parameter int BIT_PER_PIXEL = 8,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int COL_W         = 10,
  parameter int ROW_W         = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [BIT_PER_PIXEL-1:0] in_pixel,
  output logic [BIT_PER_PIXEL-1:0] pixel_0,
  output logic [BIT_PER_PIXEL-1:0] pixel_1,
  output logic [BIT_PER_PIXEL-1:0] pixel_2,
  output logic [BIT_PER_PIXEL-1:0] pixel_3,
  output logic [BIT_PER_PIXEL-1:0] pixel_4,
  output logic [BIT_PER_PIXEL-1:0] pixel_5,
  output logic [BIT_PER_PIXEL-1:0] pixel_6,
  output logic [BIT_PER_PIXEL-1:0] pixel_7,
  output logic [BIT_PER_PIXEL-1:0] pixel_8,
  output logic                     win_valid,
  output logic [COL_W-1:0]         win_col,
  output logic [ROW_W-1:0]         win_row,
  output logic                     frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]         col, col_cur, col_p1;
  logic [ROW_W-1:0]         row, row_cur, row_p1;
  logic [BIT_PER_PIXEL-1:0] lb_a [IMG_WIDTH];
  logic [BIT_PER_PIXEL-1:0] lb_b [IMG_WIDTH];
  logic [BIT_PER_PIXEL-1:0] lb_a_rd, lb_b_rd;
  logic [BIT_PER_PIXEL-1:0] tap_p0  [9];
  logic [BIT_PER_PIXEL-1:0] tap_nxt [9];
  logic [BIT_PER_PIXEL-1:0] win_p1  [9];
  logic                     win_hit, vld_p1, done_p1;

  // A start-of-frame pixel is position (0,0) whatever the counters say.
  always_comb begin
    col_cur = in_sof ? '0 : col;
    row_cur = in_sof ? '0 : row;
  end

  assign lb_a_rd = lb_a[col_cur];
  assign lb_b_rd = lb_b[col_cur];
  assign win_hit = (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);

  always_comb begin
    tap_nxt[0] = tap_p0[1];
    tap_nxt[1] = tap_p0[2];
    tap_nxt[2] = lb_b_rd;
    tap_nxt[3] = tap_p0[4];
    tap_nxt[4] = tap_p0[5];
    tap_nxt[5] = lb_a_rd;
    tap_nxt[6] = tap_p0[7];
    tap_nxt[7] = tap_p0[8];
    tap_nxt[8] = in_pixel;
  end

  // Line buffers: plain RAM, never reset, read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_b[col_cur] <= lb_a_rd;
      lb_a[col_cur] <= in_pixel;
    end
  end

  // Stage p0: raster position counters and the shifting 3x3 tap array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
      for (int i = 0; i < 9; i++) tap_p0[i] <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < 9; i++) tap_p0[i] <= tap_nxt[i];
      if (col_cur == COL_LAST) begin
        col <= '0;
        row <= (row_cur == ROW_LAST) ? '0 : row_cur + ROW_ONE;
      end else begin
        col <= col_cur + COL_ONE;
        row <= row_cur;
      end
    end
  end

  // Stage p1: registered window, held between valid pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      col_p1  <= '0;
      row_p1  <= '0;
      for (int i = 0; i < 9; i++) win_p1[i] <= '0;
    end else begin
      vld_p1  <= in_valid && win_hit;
      done_p1 <= in_valid && (col_cur == COL_LAST) && (row_cur == ROW_LAST);
      if (in_valid && win_hit) begin
        col_p1 <= col_cur - COL_ONE;
        row_p1 <= row_cur - ROW_ONE;
        for (int i = 0; i < 9; i++) win_p1[i] <= tap_nxt[i];
      end
    end
  end

  assign pixel_0    = win_p1[0];
  assign pixel_1    = win_p1[1];
  assign pixel_2    = win_p1[2];
  assign pixel_3    = win_p1[3];
  assign pixel_4    = win_p1[4];
  assign pixel_5    = win_p1[5];
  assign pixel_6    = win_p1[6];
  assign pixel_7    = win_p1[7];
  assign pixel_8    = win_p1[8];
  assign win_valid  = vld_p1;
  assign win_col    = col_p1;
  assign win_row    = row_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_line_window_3x3.sv
// Bench for line_window_3x3 on a 4x4 image: the reference model keeps the
// whole frame as a 2D array and cuts each expected neighbourhood out of it.
module tb_line_window_3x3;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pixel = '0;
  logic [7:0] pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8;
  logic       win_valid, frame_done;
  logic [1:0] win_col, win_row;

  line_window_3x3 #(
    .BIT_PER_PIXEL(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(2), .ROW_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .pixel_0(pixel_0), .pixel_1(pixel_1), .pixel_2(pixel_2), .pixel_3(pixel_3), .pixel_4(pixel_4),
    .pixel_5(pixel_5), .pixel_6(pixel_6), .pixel_7(pixel_7), .pixel_8(pixel_8),
    .win_valid(win_valid), .win_col(win_col), .win_row(win_row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errs = 0;
  int          mr = 0, mc = 0;
  logic [7:0]  img [H][W];
  logic [71:0] last_win = '0;
  logic [3:0]  last_rc = '0;
  int          dut_wins = 0, dut_fd = 0;
  bit          got_first = 0;
  logic [71:0] first_win = '0;

  function automatic logic [71:0] window_out();
    return {pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8};
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] p);
    bit exp_wv = 0;
    bit exp_fd = 0;
    logic [71:0] w = '0;
    in_valid = v; in_sof = s; in_pixel = p;
    if (v) begin
      if (s) begin mr = 0; mc = 0; end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        exp_wv = 1;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            w = {w[63:0], img[mr-2+dr][mc-2+dc]};
        last_win = w;
        last_rc  = {2'(mr - 1), 2'(mc - 1)};
      end
      exp_fd = (mr == H - 1) && (mc == W - 1);
      mc++;
      if (mc == W) begin
        mc = 0; mr++;
        if (mr == H) mr = 0;
      end
    end
    @(posedge clk); #1;
    chk("win_valid", {71'd0, win_valid}, {71'd0, exp_wv});
    chk("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
    chk("window", window_out(), last_win);
    chk("coord", {68'd0, win_row, win_col}, {68'd0, last_rc});
    dut_wins += int'(win_valid);
    dut_fd   += int'(frame_done);
    if (win_valid && !got_first) begin got_first = 1; first_win = window_out(); end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_win"}, window_out(), 72'd0);
    chk({tag, "_ctl"}, {68'd0, win_valid, frame_done, win_row, win_col}, 72'd0);
  endtask

  task automatic frame_ramp(input bit idle_gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1, (r == 0 && c == 0), 8'(16 * r + c));
        if (idle_gaps) step(0, 0, 8'($urandom));
      end
  endtask

  task automatic frame_rand(input bit sof);
    for (int i = 0; i < W * H; i++) step(1, sof && (i == 0), 8'($urandom));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    reset_n = 1'b1;
    step(0, 0, 8'h00);

    // T1/T3: ramp frame, continuous valid
    dut_wins = 0; dut_fd = 0; got_first = 0;
    frame_ramp(0);
    step(0, 0, 8'h00);
    chk("t1_first_win", first_win, 72'h00_01_02_10_11_12_20_21_22);
    chk("t1_win_count", 72'(dut_wins), 72'd4);
    chk("t1_fd_count", 72'(dut_fd), 72'd1);
    chk("t3_last_p8", {64'd0, pixel_8}, 72'h33);

    // T2: idle cycle after every pixel
    dut_wins = 0; dut_fd = 0; got_first = 0;
    frame_ramp(1);
    chk("t2_first_win", first_win, 72'h00_01_02_10_11_12_20_21_22);
    chk("t2_win_count", 72'(dut_wins), 72'd4);

    // T4: back-to-back frames, second without sof
    dut_wins = 0; dut_fd = 0;
    frame_rand(1);
    frame_rand(0);
    step(0, 0, 8'h00);
    chk("t4_win_count", 72'(dut_wins), 72'd8);
    chk("t4_fd_count", 72'(dut_fd), 72'd2);

    // T5: sof restarts the frame at pixel (2,1)
    dut_fd = 0;
    for (int i = 0; i < 9; i++) step(1, (i == 0), 8'($urandom));
    frame_rand(1);
    chk("t5_fd_count", 72'(dut_fd), 72'd1);

    // T6: reset mid-row 2, after a window has been presented
    for (int i = 0; i < 11; i++) step(1, (i == 0), 8'($urandom));
    chk("t6_pre_valid", {71'd0, win_valid}, 72'd1);
    reset_n = 1'b0;
    #1 chk_zero("t6_async");
    mr = 0; mc = 0; last_win = '0; last_rc = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    dut_fd = 0;
    frame_rand(0);
    chk("t6_fd_count", 72'(dut_fd), 72'd1);

    // Random valid gaps and occasional sof
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), 8'($urandom));
    step(0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
